// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between the instruction and data channels of a core.
// Define ARB_RR_EN for alternating priority; fixed data-over-instruction otherwise.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] IGNT = 2'd1;
   localparam logic [1:0] DGNT = 2'd2;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       w_dReq;
   logic       w_access;
   logic       w_iFirst;
   logic       w_done;

   assign w_dReq   = dREN | dWEN;
   assign w_access = (ramstate == RAM_ACCESS);
   assign w_done   = w_access & (((r_state == IGNT) & iREN) | ((r_state == DGNT) & w_dReq));

`ifdef ARB_RR_EN
   logic r_prio;

   // Flip priority after every completed transfer so both channels alternate under contention.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_prio <= 1'b0;
      else if (w_done)
         r_prio <= ~r_prio;
   end

   assign w_iFirst = iREN & (~w_dReq | r_prio);
`else
   assign w_iFirst = iREN & ~w_dReq;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_iFirst)
               w_next = IGNT;
            else if (w_dReq)
               w_next = DGNT;
         end
         IGNT: begin
            if (!iREN || w_access)
               w_next = IDLE;
         end
         DGNT: begin
            if (!w_dReq || w_access)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // A withdrawn request leaves everything idle, so the caller never sees a wait=0 pulse.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      if (r_state == IGNT && iREN) begin
         ramREN  = 1'b1;
         ramaddr = iaddr;
         iwait   = ~w_access;
         iload   = ramload;
      end else if (r_state == DGNT && w_dReq) begin
         ramaddr = daddr;
         if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
         end else begin
            ramREN = 1'b1;
         end
         dwait = ~w_access;
         dload = ramload;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle reference model plus directed scenarios.
// Honours ARB_RR_EN in the same way as the design.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(32), .WORD_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // Reference model: who owns the RAM port (0 none, 1 instruction, 2 data) and the priority flag.
   int owner;
   bit flagM;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         owner = 0;
         flagM = 1'b0;
      end else begin
         case (owner)
            0: begin
               if ((dREN || dWEN) && iREN)
                  owner = (RR && flagM) ? 1 : 2;
               else if (dREN || dWEN)
                  owner = 2;
               else if (iREN)
                  owner = 1;
            end
            1: begin
               if (!iREN) owner = 0;
               else if (ramstate == 2'd2) begin owner = 0; flagM = !flagM; end
            end
            default: begin
               if (!(dREN || dWEN)) owner = 0;
               else if (ramstate == 2'd2) begin owner = 0; flagM = !flagM; end
            end
         endcase
      end
   end

   // Compare every cycle on the falling edge, when inputs and combinational outputs are settled.
   always @(negedge CLK) begin
      logic        eREN, eWEN, eIw, eDw;
      logic [31:0] eAddr, eStore, eIl, eDl;
      eREN = 0; eWEN = 0; eIw = 1; eDw = 1;
      eAddr = 0; eStore = 0; eIl = 0; eDl = 0;
      if (owner == 1 && iREN) begin
         eREN = 1; eAddr = iaddr; eIw = (ramstate != 2'd2); eIl = ramload;
      end
      if (owner == 2 && (dREN || dWEN)) begin
         eAddr = daddr;
         if (dWEN) begin eWEN = 1; eStore = dstore; end
         else eREN = 1;
         eDw = (ramstate != 2'd2); eDl = ramload;
      end
      checkOutput("cyc_ramREN", {31'd0, ramREN}, {31'd0, eREN});
      checkOutput("cyc_ramWEN", {31'd0, ramWEN}, {31'd0, eWEN});
      checkOutput("cyc_ramaddr", ramaddr, eAddr);
      checkOutput("cyc_ramstore", ramstore, eStore);
      checkOutput("cyc_iwait", {31'd0, iwait}, {31'd0, eIw});
      checkOutput("cyc_dwait", {31'd0, dwait}, {31'd0, eDw});
      checkOutput("cyc_iload", iload, eIl);
      checkOutput("cyc_dload", dload, eDl);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic iR, input logic [31:0] ia, input logic dR, input logic dW,
                                input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs);
      step();
      iREN = iR; iaddr = ia; dREN = dR; dWEN = dW; daddr = da; dstore = ds; ramstate = rs;
      #2;
   endtask

   initial begin
      int wenCnt, dLowCnt, cyc, dDone, iDone, nDone;
      int order[4];
      int expOrder[4];
      nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
      #3;
      checkOutput("rst_ramREN", {31'd0, ramREN}, 32'd0);
      checkOutput("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      checkOutput("rst_ramaddr", ramaddr, 32'd0);
      checkOutput("rst_iwait", {31'd0, iwait}, 32'd1);
      checkOutput("rst_dwait", {31'd0, dwait}, 32'd1);
      step(); step();
      nRST = 1;

      // T1: instruction fetch completes on the first grant cycle
      ramload = 32'h1234_5678;
      applyStimulus(1, 32'h40, 0, 0, 0, 0, 2'd0);
      checkOutput("t1_idle_ramREN", {31'd0, ramREN}, 32'd0);
      applyStimulus(1, 32'h40, 0, 0, 0, 0, 2'd2);
      checkOutput("t1_ramREN", {31'd0, ramREN}, 32'd1);
      checkOutput("t1_ramaddr", ramaddr, 32'h40);
      checkOutput("t1_iwait", {31'd0, iwait}, 32'd0);
      checkOutput("t1_iload", iload, 32'h1234_5678);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'd0);
      checkOutput("t1_after_ramREN", {31'd0, ramREN}, 32'd0);

      // T2: data write, three BUSY cycles then ACCESS
      applyStimulus(0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 2'd0);
      wenCnt = 0; dLowCnt = 0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, (k < 3) ? 2'd1 : 2'd2);
         if (ramWEN) wenCnt++;
         if (!dwait) dLowCnt++;
         if (k == 3) begin
            checkOutput("t2_ramstore", ramstore, 32'hDEAD_BEEF);
            checkOutput("t2_dwait_access", {31'd0, dwait}, 32'd0);
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 2'd0);
      checkOutput("t2_wen_cycles", wenCnt, 32'd4);
      checkOutput("t2_dwait_low_cycles", dLowCnt, 32'd1);
      checkOutput("t2_after_ramWEN", {31'd0, ramWEN}, 32'd0);

      // T3: simultaneous requests, data goes first
      ramload = 32'h0BAD_F00D;
      applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 2'd2);
      dDone = -1; iDone = -1;
      for (cyc = 1; cyc < 20 && (dDone < 0 || iDone < 0); cyc++) begin
         step();
         if (dDone >= 0) dREN = 0;
         if (iDone >= 0) iREN = 0;
         #2;
         if (dREN && !dwait) dDone = cyc;
         if (iREN && !iwait) iDone = cyc;
         if (dDone < 0) checkOutput("t3_iwait_held", {31'd0, iwait}, 32'd1);
      end
      checkOutput("t3_d_done_cycle", dDone, 32'd1);
      checkOutput("t3_i_done_cycle", iDone, 32'd3);
      step(); iREN = 0; dREN = 0; #2;

      // T4: both channels held for four transfers
      if (RR) expOrder = '{2, 1, 2, 1};
      else    expOrder = '{2, 2, 2, 2};
      applyStimulus(1, 32'h84, 1, 0, 32'h204, 0, 2'd2);
      nDone = 0;
      for (cyc = 0; cyc < 30 && nDone < 4; cyc++) begin
         step(); #2;
         if (dREN && !dwait) begin order[nDone] = 2; nDone++; end
         else if (iREN && !iwait) begin order[nDone] = 1; nDone++; end
      end
      checkOutput("t4_transfers", nDone, 32'd4);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("t4_order%0d", k), (k < nDone) ? order[k] : 0, expOrder[k]);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'd0);

      // T5: ERROR holds the data grant until ACCESS arrives
      ramload = 32'hCAFE_F00D;
      applyStimulus(0, 0, 1, 0, 32'h300, 0, 2'd0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 0, 1, 0, 32'h300, 0, 2'd3);
         checkOutput("t5_err_ramREN", {31'd0, ramREN}, 32'd1);
         checkOutput("t5_err_dwait", {31'd0, dwait}, 32'd1);
      end
      applyStimulus(0, 0, 1, 0, 32'h300, 0, 2'd2);
      checkOutput("t5_dwait", {31'd0, dwait}, 32'd0);
      checkOutput("t5_dload", dload, 32'hCAFE_F00D);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'd0);

      // T6: reset mid-grant, then withdrawn data request
      applyStimulus(1, 32'h44, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 32'h44, 0, 0, 0, 0, 2'd1);
      checkOutput("t6_grant_ramREN", {31'd0, ramREN}, 32'd1);
      nRST = 0;
      #1;
      checkOutput("t6_rst_ramREN", {31'd0, ramREN}, 32'd0);
      checkOutput("t6_rst_iwait", {31'd0, iwait}, 32'd1);
      checkOutput("t6_rst_dwait", {31'd0, dwait}, 32'd1);
      step(); nRST = 1; iREN = 0;
      applyStimulus(0, 0, 1, 0, 32'h500, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 32'h500, 0, 2'd1);
      checkOutput("t6_dgnt_ramREN", {31'd0, ramREN}, 32'd1);
      dREN = 0; ramstate = 2'd2;
      #1;
      checkOutput("t6_wd_ramREN", {31'd0, ramREN}, 32'd0);
      checkOutput("t6_wd_dwait", {31'd0, dwait}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'd0);
      checkOutput("t6_idle_dwait", {31'd0, dwait}, 32'd1);
      applyStimulus(1, 32'h48, 0, 0, 0, 0, 2'd2);
      applyStimulus(1, 32'h48, 0, 0, 0, 0, 2'd2);
      checkOutput("t6_regrant_iwait", {31'd0, iwait}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'd0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
